// File: rtl/seq_pkg.sv
// Shared types and constants for the sequencer program loader.
package seq_pkg;

    localparam int WORD_WIDTH    = 16;
    localparam int RAM_ADDR_BITS = 11;

    localparam logic [WORD_WIDTH-1:0] MASK_NONE = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_LO,
        ST_HI,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } ld_state_e;

endpackage

// File: rtl/loader_csum.sv
// 8-bit wrapping checksum accumulator. zero_o reports whether the value being
// loaded this cycle is zero, so the caller can judge the final byte on its edge.
module loader_csum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_i,
    input  logic       add_i,
    input  logic [7:0] byte_i,
    output logic       zero_o
);

    logic [7:0] sum_q, sum_d;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        sum_d = sum_q;
        if (init_i) begin
            sum_d = byte_i;
        end else if (add_i) begin
            sum_d = sum_q + byte_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign zero_o = (sum_d == 8'h00);

endmodule

// File: rtl/seq_prog_loader.sv
// Program-RAM writer: parses count/words/checksum from a byte stream, writes
// words from address 0 and keeps the sequencer halted until a good image lands.
module seq_prog_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = seq_pkg::WORD_WIDTH
) (
    input  logic                              CLKIN,
    input  logic                              RESETN,
    input  logic                              START,
    input  logic [7:0]                        RX_DATA,
    input  logic                              RX_VALID,
    output logic                              RX_READY,
    output logic [seq_pkg::RAM_ADDR_BITS-1:0] WADDR,
    output logic [WORD_WIDTH-1:0]             WDATA,
    output logic                              WE,
    output logic                              WCLKE,
    output logic [WORD_WIDTH-1:0]             MASK,
    output logic                              HALT,
    output logic                              DONE,
    output logic                              ERR
);

    import seq_pkg::*;

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    ld_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rdy_q, we_q, halt_q, done_q, err_q;
    logic                  xfer, cs_init, cs_add, cs_zero;

    assign xfer = RX_VALID & rdy_q;

    loader_csum u_csum (
        .clk    (CLKIN),
        .rst_n  (RESETN),
        .init_i (cs_init),
        .add_i  (cs_add),
        .byte_i (RX_DATA),
        .zero_o (cs_zero)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        cs_init = 1'b0;
        cs_add  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (START) state_d = ST_COUNT;
            ST_COUNT: if (xfer) begin
                // A zero count byte stands for a full 2^ADDR_WIDTH-word image.
                cnt_d   = (RX_DATA == 8'h00) ? CNT_FULL : CW'(RX_DATA);
                addr_d  = '0;
                cs_init = 1'b1;
                state_d = ST_LO;
            end
            ST_LO: if (xfer) begin
                wdata_d[7:0] = RX_DATA;
                cs_add       = 1'b1;
                state_d      = ST_HI;
            end
            ST_HI: if (xfer) begin
                wdata_d[15:8] = RX_DATA;
                cs_add        = 1'b1;
                state_d       = ST_WRITE;
            end
            ST_WRITE: begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? ST_CHK : ST_LO;
            end
            ST_CHK: if (xfer) begin
                cs_add  = 1'b1;
                state_d = cs_zero ? ST_DONE : ST_ERR;
            end
            ST_DONE, ST_ERR: if (START) state_d = ST_COUNT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            halt_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            rdy_q   <= state_d inside {ST_COUNT, ST_LO, ST_HI, ST_CHK};
            we_q    <= (state_d == ST_WRITE);
            halt_q  <= (state_d != ST_DONE);
            done_q  <= (state_q == ST_CHK) && (state_d == ST_DONE);
            err_q   <= (state_d == ST_ERR);
        end
    end

    assign RX_READY = rdy_q;
    assign WADDR    = {{(RAM_ADDR_BITS-ADDR_WIDTH){1'b0}}, addr_q};
    assign WDATA    = wdata_q;
    assign WE       = we_q;
    assign WCLKE    = we_q;
    assign MASK     = MASK_NONE;
    assign HALT     = halt_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule
